// File: rtl/rom_arbiter.sv
// Shares one single-port ROM between a VGA scanout reader and a CPU reader.
// VGA normally wins; a starved CPU is forced a slot. Results return at fixed latency 2.
module rom_arbiter #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 160000,
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [31:0]       vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_err,
    output logic [31:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    // tag      | meaning
    // TAG_IDLE | no read issued this slot
    // TAG_VGA  | slot owned by the VGA reader
    // TAG_CPU  | slot owned by the CPU (normal or forced)
    typedef enum logic [1:0] {TAG_IDLE, TAG_VGA, TAG_CPU} tag_t;

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [31:0]     DEPTH_W    = 32'(DEPTH);

    logic [SW-1:0] starve_cnt;
    logic [31:0]   last_addr;
    tag_t          issue_tag;
    logic [31:0]   issue_addr;
    logic          forced;
    logic          drop;
    tag_t          s1_tag;
    logic          s1_oor;
    logic          s1_miss;

    // Nothing is issued while in reset so rom_addr and cpu_gnt read back as 0.
    always_comb begin
        issue_tag  = TAG_IDLE;
        issue_addr = last_addr;
        drop       = 1'b0;
        forced     = (starve_cnt == STARVE_TOP) && cpu_req;
        if (!rst_n) begin
            issue_tag = TAG_IDLE;
        end else if (forced) begin
            issue_tag  = TAG_CPU;
            issue_addr = cpu_addr;
            drop       = vga_req;
        end else if (vga_req) begin
            issue_tag  = TAG_VGA;
            issue_addr = vga_addr;
        end else if (cpu_req) begin
            issue_tag  = TAG_CPU;
            issue_addr = cpu_addr;
        end
    end

    assign rom_addr = issue_addr;
    assign cpu_gnt  = (issue_tag == TAG_CPU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            last_addr  <= '0;
            s1_tag     <= TAG_IDLE;
            s1_oor     <= 1'b0;
            s1_miss    <= 1'b0;
            vga_valid  <= 1'b0;
            vga_data   <= '0;
            vga_miss   <= 1'b0;
            cpu_valid  <= 1'b0;
            cpu_data   <= '0;
            cpu_err    <= 1'b0;
        end else begin
            if (issue_tag != TAG_IDLE) begin
                last_addr <= issue_addr;
            end

            if (!cpu_req || cpu_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            s1_tag  <= issue_tag;
            s1_oor  <= (issue_addr >= DEPTH_W);
            s1_miss <= drop;

            // Stage 2: rom_data belongs to s1_tag's request this cycle.
            vga_valid <= (s1_tag == TAG_VGA);
            cpu_valid <= (s1_tag == TAG_CPU);
            vga_miss  <= s1_miss;
            cpu_err   <= (s1_tag == TAG_CPU) && s1_oor;
            if (s1_tag == TAG_VGA) begin
                vga_data <= s1_oor ? '0 : rom_data;
            end
            if (s1_tag == TAG_CPU) begin
                cpu_data <= s1_oor ? '0 : rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random traffic,
// scored against a cycle-slot reference model of the arbitration rules.
module tb_rom_arbiter;

    localparam int DW     = 8;
    localparam int DEPTH  = 160000;
    localparam int SMAX   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_req = 1'b0;
    logic [31:0]   vga_addr = '0;
    logic          vga_valid;
    logic [DW-1:0] vga_data;
    logic          vga_miss;
    logic          cpu_req = 1'b0;
    logic [31:0]   cpu_addr = '0;
    logic          cpu_gnt;
    logic          cpu_valid;
    logic [DW-1:0] cpu_data;
    logic          cpu_err;
    logic [31:0]   rom_addr;
    logic [DW-1:0] rom_data = '0;

    rom_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid),
        .vga_data(vga_data), .vga_miss(vga_miss),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_err(cpu_err),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [31:0] a);
        logic [31:0] t;
        t = a * 12 + (a >> 8);
        return t[DW-1:0];
    endfunction

    // Synchronous ROM: data for the address presented in the previous cycle.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected registered outputs per cycle, in a ring of slots.
    logic          e_vv [4];
    logic          e_cv [4];
    logic          e_miss [4];
    logic          e_err [4];
    logic [DW-1:0] e_d [4];
    int            cyc = 0;
    int            m_st = 0;
    logic [31:0]   m_last = '0;
    logic [DW-1:0] m_vd = '0;
    logic [DW-1:0] m_cd = '0;
    logic          m_gnt = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            e_vv[i] = 0; e_cv[i] = 0; e_miss[i] = 0; e_err[i] = 0; e_d[i] = '0;
        end
        m_st = 0; m_last = '0; m_vd = '0; m_cd = '0; m_gnt = 0;
    endtask

    // One cycle: check results due now, drive inputs, check issue, advance model.
    task automatic step(input logic vr, input logic [31:0] va,
                        input logic cr, input logic [31:0] ca);
        int s, ns, win;
        logic forced, drop, oor;
        logic [31:0] ea;
        @(negedge clk);
        s = cyc % 4;
        chk("vga_valid", vga_valid, e_vv[s]);
        chk("cpu_valid", cpu_valid, e_cv[s]);
        chk("vga_miss", vga_miss, e_miss[s]);
        chk("cpu_err", cpu_err, e_err[s]);
        if (e_vv[s]) m_vd = e_d[s];
        if (e_cv[s]) m_cd = e_d[s];
        chk("vga_data", vga_data, m_vd);
        chk("cpu_data", cpu_data, m_cd);
        chk("both_valid", vga_valid && cpu_valid, 0);
        e_vv[s] = 0; e_cv[s] = 0; e_miss[s] = 0; e_err[s] = 0;

        vga_req = vr; vga_addr = va; cpu_req = cr; cpu_addr = ca;
        #1;
        forced = cr && (m_st == SMAX);
        win    = forced ? 2 : (vr ? 1 : (cr ? 2 : 0));
        drop   = forced && vr;
        ea     = (win == 1) ? va : ((win == 2) ? ca : m_last);
        m_last = ea;
        m_gnt  = (win == 2);
        chk("rom_addr", rom_addr, ea);
        chk("cpu_gnt", cpu_gnt, m_gnt);

        oor = (ea >= DEPTH);
        ns  = (cyc + 2) % 4;
        e_vv[ns]   = (win == 1);
        e_cv[ns]   = (win == 2);
        e_miss[ns] = drop;
        e_err[ns]  = (win == 2) && oor;
        e_d[ns]    = oor ? '0 : rom_fn(ea);
        if (!cr || m_gnt) m_st = 0;
        else if (m_st < SMAX) m_st = m_st + 1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vv"}, vga_valid, 0);
        chk({tag, "_vd"}, vga_data, 0);
        chk({tag, "_vm"}, vga_miss, 0);
        chk({tag, "_gnt"}, cpu_gnt, 0);
        chk({tag, "_cv"}, cpu_valid, 0);
        chk({tag, "_cd"}, cpu_data, 0);
        chk({tag, "_err"}, cpu_err, 0);
        chk({tag, "_addr"}, rom_addr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        vga_req = 1; vga_addr = 32'd77; cpu_req = 1; cpu_addr = 32'd88;
        #1;
        check_reset_outputs("rst_a");
        @(negedge clk);
        check_reset_outputs("rst_b");
        chk("rst_starve", dut.starve_cnt, 0);
        rst_n = 1;
        vga_req = 0; cpu_req = 0; vga_addr = '0; cpu_addr = '0;
        model_clear();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom % 8;
        if (r == 0) return 32'(DEPTH - 1 + ($urandom % 3));
        if (r == 1) return 32'hFFFF_FFFF;
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        logic        c_pend;
        logic [31:0] c_a;
        int          gnt_idx;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("init");
        do_reset();

        // Single VGA read of address 5 returns rom_fn(5) = 0x3C two cycles later.
        step(1, 32'd5, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("vga5_data", vga_data, 8'h3C);

        // Simultaneous requests: VGA first, CPU in the next slot.
        step(1, 32'd10, 1, 32'd20);
        step(0, 0, 1, 32'd20);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Starvation: VGA held for 20 cycles, CPU forced on the 17th.
        c_pend = 1; gnt_idx = -1;
        for (int i = 0; i < 20; i++) begin
            step(1, 32'(1000 + i), c_pend, 32'd4242);
            if (cpu_gnt && gnt_idx < 0) gnt_idx = i + 1;
            if (m_gnt) c_pend = 0;
        end
        chk("starve_gnt_cycle", gnt_idx, 17);
        chk("starve_cleared", dut.starve_cnt, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Out-of-range CPU address at the boundary.
        step(0, 0, 1, 32'd160000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("oor_err", cpu_err, 1);
        chk("oor_data", cpu_data, 0);
        step(0, 0, 1, 32'd159999);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Reset while a VGA read is in flight: nothing emerges afterwards.
        step(1, 32'd7, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Alternating VGA / CPU issues for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) step(1, rand_addr(), 0, 0);
            else            step(0, 0, 1, rand_addr());
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Random traffic with CPU handshake protocol.
        c_pend = 0; c_a = '0;
        for (int i = 0; i < 600; i++) begin
            if (!c_pend && ($urandom % 3 == 0)) begin
                c_pend = 1; c_a = rand_addr();
            end
            step(($urandom % 8) < 5, rand_addr(), c_pend, c_a);
            if (m_gnt) begin
                c_pend = ($urandom % 2 == 0);
                c_a = rand_addr();
            end
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
